pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (successor of the fixed MEM->WB latch) for
//  any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Adds a valid/ready handshake,
//  a 2-entry skid buffer so in_ready is fully registered, a synchronous flush for
//  hazard/branch kill, and an occupancy readout for the forwarding/hazard unit.
// PARAMETERS
//  DATA_W  32  width of each data word (matches `WORD)
//  NDATA   2   number of data words carried (e.g. mem_result, alu_result)
//  DEST_W  5   destination register index width
//  CTRL_W  3   control bits carried (bit0 wb, bit1 mem_r, bit2 terminate by convention)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-high reset
//  flush      in   1              synchronous kill of all held entries
//  in_valid   in   1              upstream beat valid
//  in_ready   out  1              buffer can accept (registered)
//  in_ctrl    in   CTRL_W         control bits
//  in_dest    in   DEST_W         destination register
//  in_data    in   NDATA*DATA_W   data words, word k at [k*DATA_W +: DATA_W]
//  out_valid  out  1              downstream beat valid
//  out_ready  in   1              downstream accepts
//  out_ctrl   out  CTRL_W         held control bits
//  out_dest   out  DEST_W         held destination
//  out_data   out  NDATA*DATA_W   held data words
//  occupancy  out  2              entries held: 0,1,2
//  stall_cnt  out  32             output-stall cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  - Storage: main entry M (drives out_*), skid entry S. out_valid = M.valid.
//  - Reset (async, rst=1): M.valid=S.valid=0, all payload regs 0, in_ready=1,
//    occupancy=0, stall_cnt=0. Outputs stable at these values while rst held.
//  - acc = in_valid & in_ready; pop = out_valid & out_ready; evaluated each posedge.
//  - Latency: accepted beat appears on out_* the next cycle when M empty or popping.
//  - Transitions (occupancy): 0: acc -> M<=in, 1.
//    1: acc&pop -> M<=in, 1; acc&~pop -> S<=in, 2; ~acc&pop -> 0; else hold.
//    2: pop -> M<=S, S.valid=0, 1; else hold. in_valid ignored (in_ready=0).
//  - in_ready registered: next in_ready = (next occupancy < 2). Never combinational
//    from out_ready.
//  - Order preserved: S always younger than M; no beat duplicated or dropped
//    except by flush.
//  - flush=1: next cycle M.valid=S.valid=0, occupancy=0, in_ready=1. Takes
//    priority over simultaneous acc (beat dropped) and pop (pop still counts as
//    consumed downstream). Payload regs keep stale values; only valids cleared.
//  - Payload regs load only on acc/shift (no toggling on hold) for power.
//  - out_* payload undefined-by-contract when out_valid=0; bench must not check it.
//  - Reset mid-transfer: all held beats lost, no partial beat emitted.
// CONFIGURATION
//  PIPE_STAGE_SKID_PERF_EN defined: stall_cnt increments each cycle with
//   out_valid=1 & out_ready=0, saturates at 32'hFFFF_FFFF, cleared by rst only
//   (not by flush).
//  Not defined: stall_cnt tied to 32'd0, no counter flops synthesised.
// TESTING
//  1 rst asserted mid-run with occupancy=2 -> same cycle out_valid=0, in_ready=1,
//    occupancy=0; after release all payload outputs read 0.
//  2 out_ready=1, stream in_data={32'h1,32'hA},{32'h2,32'hB},{32'h3,32'hC} one per cycle
//    -> out_* carry same beats 1 cycle later, occupancy stays 1, in_ready stays 1.
//  3 out_ready=0, push beats dest=5,6,7 -> 5,6 accepted, occupancy=2, in_ready=0,
//    dest=7 held upstream; raise out_ready -> out_dest 5,6,7 in order, no gaps/dups.
//  4 occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0,
//    in_ready=1; flushed beats and concurrent beat never appear on out_*.
//  5 PIPE_STAGE_SKID_PERF_EN: hold out_valid=1,out_ready=0 for 10 cycles -> stall_cnt=10;
//    flush -> stall_cnt still 10. Without macro -> stall_cnt=0 throughout.
//  6 random in_valid/out_ready (50%) 10k cycles vs scoreboard -> order/data match,
//    in_ready never 1 when occupancy=2.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer (registered in_ready),
// synchronous flush and occupancy readout. Define PIPE_STAGE_SKID_PERF_EN to build the output-stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int NDATA  = 2,
    parameter int DEST_W = 5,
    parameter int CTRL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [DEST_W-1:0]       in_dest,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DEST_W-1:0]       out_dest,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy,
    output logic [31:0]             stall_cnt
);

    localparam int PAY_W = CTRL_W + DEST_W + NDATA*DATA_W;

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [PAY_W-1:0] m_pay_q, m_pay_d;
    logic [PAY_W-1:0] s_pay_q, s_pay_d;
    logic             in_ready_q, in_ready_d;
    logic [PAY_W-1:0] in_pay;
    logic             acc, pop;

    assign in_pay = {in_ctrl, in_dest, in_data};
    assign acc    = in_valid & in_ready_q;
    assign pop    = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_pay_d   = m_pay_q;
        s_pay_d   = s_pay_q;
        case ({m_valid_q, s_valid_q})
            2'b00: begin
                if (acc) begin
                    m_pay_d   = in_pay;
                    m_valid_d = 1'b1;
                end
            end
            2'b10: begin
                if (acc && pop) begin
                    m_pay_d = in_pay;
                end else if (acc) begin
                    s_pay_d   = in_pay;
                    s_valid_d = 1'b1;
                end else if (pop) begin
                    m_valid_d = 1'b0;
                end
            end
            2'b11: begin
                // Skid entry is always the younger beat, so it moves up on pop.
                if (pop) begin
                    m_pay_d   = s_pay_q;
                    s_valid_d = 1'b0;
                end
            end
            default: begin
                s_valid_d = 1'b0;
            end
        endcase
        // Flush clears only the valids; payload keeps stale contents.
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
        in_ready_d = ~(m_valid_d & s_valid_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_pay_q    <= '0;
            s_pay_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_pay_q    <= m_pay_d;
            s_pay_q    <= s_pay_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_valid_q;
    assign {out_ctrl, out_dest, out_data} = m_pay_q;
    assign occupancy = {m_valid_q & s_valid_q, m_valid_q ^ s_valid_q};

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= 32'd0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random stream,
// all checked against a queue-based reference of the beats in flight.
module tb_pipe_stage_skid;
    localparam int DATA_W = 32;
    localparam int NDATA  = 2;
    localparam int DEST_W = 5;
    localparam int CTRL_W = 3;
    localparam int BEAT_W = CTRL_W + DEST_W + NDATA*DATA_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [CTRL_W-1:0]       in_ctrl = '0;
    logic [DEST_W-1:0]       in_dest = '0;
    logic [NDATA*DATA_W-1:0] in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [DEST_W-1:0]       out_dest;
    logic [NDATA*DATA_W-1:0] out_data;
    logic [1:0]              occupancy;
    logic [31:0]             stall_cnt;

    logic [BEAT_W-1:0] exp_q[$];
    logic              exp_in_ready;
    logic [31:0]       exp_stall;
    int                n_checks = 0;
    int                n_fails  = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .NDATA(NDATA), .DEST_W(DEST_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_dest(in_dest), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_dest(out_dest), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [BEAT_W-1:0] b);
        in_valid = v;
        {in_ctrl, in_dest, in_data} = b;
    endtask

    function automatic logic [BEAT_W-1:0] mk_beat(input logic [2:0] c, input logic [4:0] d,
                                                  input logic [31:0] w1, input logic [31:0] w0);
        return {c, d, w1, w0};
    endfunction

    // Called at a negedge with inputs already set: check outputs, then advance one cycle.
    task automatic step();
        logic acc, pop;
        check_eq("occupancy", BEAT_W'(occupancy), BEAT_W'(exp_q.size()));
        check_eq("in_ready", BEAT_W'(in_ready), BEAT_W'(exp_in_ready));
        check_eq("out_valid", BEAT_W'(out_valid), BEAT_W'(exp_q.size() > 0));
        if (exp_q.size() > 0)
            check_eq("out_beat", {out_ctrl, out_dest, out_data}, exp_q[0]);
        check_eq("stall_cnt", BEAT_W'(stall_cnt), BEAT_W'(exp_stall));
        acc = in_valid & exp_in_ready;
        pop = (exp_q.size() > 0) & out_ready;
        @(posedge clk);
`ifdef PIPE_STAGE_SKID_PERF_EN
        if (exp_q.size() > 0 && !out_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
`endif
        if (flush) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({in_ctrl, in_dest, in_data});
        end
        exp_in_ready = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    // Asserts reset away from any edge and checks the outputs react immediately.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_out_valid", BEAT_W'(out_valid), '0);
        check_eq("rst_in_ready", BEAT_W'(in_ready), BEAT_W'(1));
        check_eq("rst_occupancy", BEAT_W'(occupancy), '0);
        check_eq("rst_stall_cnt", BEAT_W'(stall_cnt), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_in_ready = 1'b1;
        exp_stall = 32'd0;
        check_eq("rst_payload", {out_ctrl, out_dest, out_data}, '0);
    endtask

    initial begin
        exp_in_ready = 1'b1;
        exp_stall = 32'd0;
        @(negedge clk);
        do_reset();

        // Streaming with out_ready high: one-cycle latency, occupancy stays at 1.
        out_ready = 1'b1;
        drive(1'b1, mk_beat(3'd1, 5'd1, 32'h1, 32'hA)); step();
        drive(1'b1, mk_beat(3'd2, 5'd2, 32'h2, 32'hB)); step();
        check_eq("t2_occ", BEAT_W'(occupancy), BEAT_W'(1));
        drive(1'b1, mk_beat(3'd3, 5'd3, 32'h3, 32'hC)); step();
        check_eq("t2_in_ready", BEAT_W'(in_ready), BEAT_W'(1));
        drive(1'b0, '0); step(); step();

        // Backpressure: two beats fill the skid, the third waits upstream.
        out_ready = 1'b0;
        drive(1'b1, mk_beat(3'd0, 5'd5, 32'h55, 32'h50)); step();
        drive(1'b1, mk_beat(3'd0, 5'd6, 32'h66, 32'h60)); step();
        drive(1'b1, mk_beat(3'd0, 5'd7, 32'h77, 32'h70)); step();
        check_eq("t3_occ_full", BEAT_W'(occupancy), BEAT_W'(2));
        check_eq("t3_in_ready_low", BEAT_W'(in_ready), '0);
        check_eq("t3_head_dest", BEAT_W'(out_dest), BEAT_W'(5));
        out_ready = 1'b1;
        step();
        drive(1'b0, '0);
        for (int i = 0; i < 4; i++) step();

        // Reset while full drops everything.
        out_ready = 1'b0;
        drive(1'b1, mk_beat(3'd4, 5'd9, 32'h9, 32'h9)); step();
        drive(1'b1, mk_beat(3'd5, 5'd10, 32'h10, 32'h10)); step();
        check_eq("t1_occ_before_rst", BEAT_W'(occupancy), BEAT_W'(2));
        drive(1'b0, '0);
        do_reset();
        step();

        // Flush while full, with a concurrent beat offered.
        drive(1'b1, mk_beat(3'd1, 5'd11, 32'hB1, 32'hB0)); step();
        drive(1'b1, mk_beat(3'd1, 5'd12, 32'hC1, 32'hC0)); step();
        flush = 1'b1;
        drive(1'b1, mk_beat(3'd7, 5'd31, 32'hDEAD, 32'hBEEF)); step();
        flush = 1'b0;
        drive(1'b0, '0);
        check_eq("t4_out_valid", BEAT_W'(out_valid), '0);
        check_eq("t4_occ", BEAT_W'(occupancy), '0);
        check_eq("t4_in_ready", BEAT_W'(in_ready), BEAT_W'(1));
        out_ready = 1'b1;
        step(); step();

        // Stall counter: ten stalled cycles, then a flush that must not clear it.
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, mk_beat(3'd2, 5'd20, 32'h20, 32'h21)); step();
        drive(1'b0, '0);
        for (int i = 0; i < 10; i++) step();
`ifdef PIPE_STAGE_SKID_PERF_EN
        check_eq("t5_stall10", BEAT_W'(stall_cnt), BEAT_W'(10));
`else
        check_eq("t5_stall_off", BEAT_W'(stall_cnt), '0);
`endif
        out_ready = 1'b1;
        flush = 1'b1; step();
        flush = 1'b0;
        step();
`ifdef PIPE_STAGE_SKID_PERF_EN
        check_eq("t5_stall_after_flush", BEAT_W'(stall_cnt), BEAT_W'(10));
`else
        check_eq("t5_stall_off_after", BEAT_W'(stall_cnt), '0);
`endif

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom});
            out_ready = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 99) < 2);
            step();
        end
        flush = 1'b0;
        drive(1'b0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("drain_empty", BEAT_W'(occupancy), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
